// File: rtl/exec_mem_pkg.sv
// Shared definitions for the execute/memory datapath: operation encodings
// exchanged between the control unit, the ALU-control decoder and the ALU.
package exec_mem_pkg;

   localparam int DATA_W = 32;

   // ALUop values driven by the main control unit
   localparam logic [2:0] OP_MEM    = 3'b000;  // lw, sw, addi
   localparam logic [2:0] OP_BRANCH = 3'b001;  // beq, bne
   localparam logic [2:0] OP_RTYPE  = 3'b010;  // decode funct
   localparam logic [2:0] OP_ANDI   = 3'b011;
   localparam logic [2:0] OP_ORI    = 3'b100;
   localparam logic [2:0] OP_SLTI   = 3'b101;

   // R-type funct field values
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;

   // Decoded ALU operation codes
   localparam logic [2:0] CTRL_AND = 3'b000;
   localparam logic [2:0] CTRL_OR  = 3'b001;
   localparam logic [2:0] CTRL_ADD = 3'b010;
   localparam logic [2:0] CTRL_SLL = 3'b011;
   localparam logic [2:0] CTRL_SRL = 3'b100;
   localparam logic [2:0] CTRL_NOR = 3'b101;
   localparam logic [2:0] CTRL_SUB = 3'b110;
   localparam logic [2:0] CTRL_SLT = 3'b111;

endpackage

// File: rtl/data_mem_array.sv
// Word-organised data memory: asynchronous clear, synchronous write,
// combinational read gated by the read enable. No read-during-write bypass,
// so a same-cycle read shows the old word until the write edge.
module data_mem_array
   import exec_mem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] index,
   input  logic [DATA_W-1:0] wdata,
   input  logic              read_en,
   input  logic              write_en,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage: whole array clears while rst_n is low, otherwise write on enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[ADDR_W'(i)] <= '0;
         end
      end else if (write_en) begin
         mem[index] <= wdata;
      end
   end

   // Read port: zero when not reading so the load bus idles quietly
   always_comb begin
      rdata = '0;
      if (read_en) begin
         rdata = mem[index];
      end
   end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute-and-memory datapath for the 5-stage MIPS pipeline: ALU-control
// decoder, 32-bit ALU with zero flag, and the data memory. The ALU works on
// ID/EX operands while the memory uses the separate EX/MEM address port.
module exec_mem_unit
   import exec_mem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        alu_op,
   input  logic [5:0]        funct,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic [4:0]        shamt,
   output logic [2:0]        alu_ctrl,
   output logic [DATA_W-1:0] alu_result,
   output logic              zero,
   input  logic [DATA_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_read,
   input  logic              mem_write,
   output logic [DATA_W-1:0] mem_rdata
);

   logic [ADDR_W-1:0] word_index;
   // Byte offset and bits above the memory depth are deliberately dropped:
   // addresses wrap and misalignment is not trapped.
   logic              unused_addr_bits;

   assign word_index       = mem_addr[ADDR_W+1:2];
   assign unused_addr_bits = ^{mem_addr[DATA_W-1:ADDR_W+2], mem_addr[1:0]};

   // ALU-control decode; any unmatched (including unknown) code falls to ADD
   always_comb begin
      alu_ctrl = CTRL_ADD;
      case (alu_op)
         OP_MEM:    alu_ctrl = CTRL_ADD;
         OP_BRANCH: alu_ctrl = CTRL_SUB;
         OP_ANDI:   alu_ctrl = CTRL_AND;
         OP_ORI:    alu_ctrl = CTRL_OR;
         OP_SLTI:   alu_ctrl = CTRL_SLT;
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_ctrl = CTRL_ADD;
               FN_SUB:  alu_ctrl = CTRL_SUB;
               FN_AND:  alu_ctrl = CTRL_AND;
               FN_OR:   alu_ctrl = CTRL_OR;
               FN_NOR:  alu_ctrl = CTRL_NOR;
               FN_SLT:  alu_ctrl = CTRL_SLT;
               FN_SLL:  alu_ctrl = CTRL_SLL;
               FN_SRL:  alu_ctrl = CTRL_SRL;
               default: alu_ctrl = CTRL_ADD;
            endcase
         end
         default:   alu_ctrl = CTRL_ADD;
      endcase
   end

   // ALU datapath; shifts take their amount from shamt and ignore src_a
   always_comb begin
      alu_result = src_a + src_b;
      case (alu_ctrl)
         CTRL_AND: alu_result = src_a & src_b;
         CTRL_OR:  alu_result = src_a | src_b;
         CTRL_ADD: alu_result = src_a + src_b;
         CTRL_SLL: alu_result = src_b << shamt;
         CTRL_SRL: alu_result = src_b >> shamt;
         CTRL_NOR: alu_result = ~(src_a | src_b);
         CTRL_SUB: alu_result = src_a - src_b;
         CTRL_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default:  alu_result = src_a + src_b;
      endcase
   end

   // Zero flag covers every operation, not only SUB
   always_comb begin
      zero = (alu_result == '0);
   end

   data_mem_array #(
      .ADDR_W (ADDR_W)
   ) u_data_mem (
      .clk      (clk),
      .rst_n    (rst_n),
      .index    (word_index),
      .wdata    (mem_wdata),
      .read_en  (mem_read),
      .write_en (mem_write),
      .rdata    (mem_rdata)
   );

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed self-checking bench for exec_mem_unit.
module tb_exec_mem_unit;

   logic        clk;
   logic        rst_n;
   logic [2:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [4:0]  shamt;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_result;
   logic        zero;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;

   logic [31:0] exp_q[$];
   int          tests;
   int          failures;

   exec_mem_unit #(
      .ADDR_W (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_op     (alu_op),
      .funct      (funct),
      .src_a      (src_a),
      .src_b      (src_b),
      .shamt      (shamt),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .zero       (zero),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_rdata  (mem_rdata)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: pop the oldest expectation and compare
   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      tests++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   // Driver: ALU operands
   task automatic drive_alu(input logic [2:0] op, input logic [5:0] f,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh);
      alu_op = op;
      funct  = f;
      src_a  = a;
      src_b  = b;
      shamt  = sh;
   endtask

   // Driver: memory port
   task automatic drive_mem(input logic [31:0] addr, input logic [31:0] wd,
                            input logic rd, input logic wr);
      mem_addr  = addr;
      mem_wdata = wd;
      mem_read  = rd;
      mem_write = wr;
   endtask

   // One ALU step: drive, queue expected result/ctrl/zero, then compare
   task automatic alu_step(input string tag, input logic [2:0] op, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                           input logic [31:0] exp_res, input logic [2:0] exp_ctrl);
      drive_alu(op, f, a, b, sh);
      exp_q.push_back(exp_res);
      exp_q.push_back({29'd0, exp_ctrl});
      exp_q.push_back({31'd0, (exp_res == 32'd0)});
      #1;
      check({tag, "_result"}, alu_result);
      check({tag, "_ctrl"}, {29'd0, alu_ctrl});
      check({tag, "_zero"}, {31'd0, zero});
   endtask

   // One memory write cycle, enables dropped on the following negedge
   task automatic mem_store(input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      drive_mem(addr, wd, 1'b0, 1'b1);
      @(negedge clk);
      drive_mem(addr, 32'd0, 1'b0, 1'b0);
   endtask

   // Combinational load check at the current time
   task automatic mem_load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      drive_mem(addr, 32'd0, 1'b1, 1'b0);
      exp_q.push_back(exp);
      #1;
      check(tag, mem_rdata);
   endtask

   initial begin
      tests    = 0;
      failures = 0;
      rst_n    = 1'b0;
      drive_alu(3'b000, 6'h00, 32'd0, 32'd0, 5'd0);
      drive_mem(32'd0, 32'd0, 1'b1, 1'b0);

      // Reset state: memory reads zero, ALU live during reset
      #12;
      mem_load("reset_rdata", 32'd8, 32'd0);
      alu_step("reset_alu_add", 3'b000, 6'h00, 32'd3, 32'd4, 5'd0, 32'd7, 3'b010);
      @(negedge clk);
      rst_n = 1'b1;

      // R-type arithmetic
      alu_step("add",      3'b010, 6'h20, 32'd7, 32'd5, 5'd0, 32'd12, 3'b010);
      alu_step("sub_zero", 3'b010, 6'h22, 32'd5, 32'd5, 5'd0, 32'd0, 3'b110);
      alu_step("slt_neg",  3'b010, 6'h2A, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 3'b111);
      alu_step("slt_pos",  3'b010, 6'h2A, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 3'b111);
      alu_step("add_wrap", 3'b010, 6'h20, 32'hFFFFFFFF, 32'd2, 5'd0, 32'd1, 3'b010);

      // Logic and shifts
      alu_step("and",      3'b010, 6'h24, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 3'b000);
      alu_step("or",       3'b010, 6'h25, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000FFF0, 3'b001);
      alu_step("nor",      3'b010, 6'h27, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 3'b101);
      alu_step("sll",      3'b010, 6'h00, 32'h12345678, 32'd1, 5'd4, 32'h00000010, 3'b011);
      alu_step("srl",      3'b010, 6'h02, 32'hFFFFFFFF, 32'h80000000, 5'd31, 32'd1, 3'b100);
      alu_step("sll_sh0",  3'b010, 6'h00, 32'h0000000F, 32'hA5A5A5A5, 5'd0, 32'hA5A5A5A5, 3'b011);

      // Non-R ALUop decode
      alu_step("op000_add",  3'b000, 6'h22, 32'd10, 32'd6, 5'd0, 32'd16, 3'b010);
      alu_step("op001_sub",  3'b001, 6'h20, 32'd0, 32'd1, 5'd0, 32'hFFFFFFFF, 3'b110);
      alu_step("op011_and",  3'b011, 6'h25, 32'h0000FFFF, 32'h00FF00FF, 5'd0, 32'h000000FF, 3'b000);
      alu_step("op100_or",   3'b100, 6'h24, 32'h0000F000, 32'h0000000F, 5'd0, 32'h0000F00F, 3'b001);
      alu_step("op101_slt",  3'b101, 6'h20, 32'h80000000, 32'd0, 5'd0, 32'd1, 3'b111);
      alu_step("op110_add",  3'b110, 6'h22, 32'd2, 32'd3, 5'd0, 32'd5, 3'b010);
      alu_step("op111_add",  3'b111, 6'h27, 32'd1, 32'd1, 5'd0, 32'd2, 3'b010);
      alu_step("funct3f_add", 3'b010, 6'h3F, 32'd9, 32'd9, 5'd0, 32'd18, 3'b010);

      // Store and load
      mem_store(32'd8, 32'hDEADBEEF);
      mem_load("load_8", 32'd8, 32'hDEADBEEF);
      mem_load("load_9_unaligned", 32'd9, 32'hDEADBEEF);
      drive_mem(32'd8, 32'd0, 1'b0, 1'b0);
      exp_q.push_back(32'd0);
      #1;
      check("load_rd_off", mem_rdata);
      mem_load("load_wrap", 32'd8 + 32'd1024, 32'hDEADBEEF);
      mem_load("load_other_empty", 32'd16, 32'd0);

      // Same-cycle read and write, no bypass
      mem_store(32'd12, 32'h00000011);
      drive_mem(32'd12, 32'h00000022, 1'b1, 1'b1);
      exp_q.push_back(32'h00000011);
      #1;
      check("rw_before_edge", mem_rdata);
      @(posedge clk);
      exp_q.push_back(32'h00000022);
      #1;
      check("rw_after_edge", mem_rdata);
      @(negedge clk);
      drive_mem(32'd12, 32'd0, 1'b0, 1'b0);

      // Asynchronous reset between edges
      mem_store(32'd4, 32'h00000055);
      mem_load("pre_reset_4", 32'd4, 32'h00000055);
      #2;
      rst_n = 1'b0;
      exp_q.push_back(32'd0);
      #1;
      check("async_clear_4", mem_rdata);
      drive_mem(32'd4, 32'h00000077, 1'b1, 1'b1);
      @(posedge clk);
      @(posedge clk);
      exp_q.push_back(32'd0);
      #1;
      check("write_in_reset", mem_rdata);
      @(negedge clk);
      drive_mem(32'd4, 32'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      mem_load("post_reset_4", 32'd4, 32'd0);
      mem_load("post_reset_8", 32'd8, 32'd0);
      mem_load("post_reset_12", 32'd12, 32'd0);

      // First write after release lands on the first rising edge
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive_mem(32'd20, 32'h00000099, 1'b1, 1'b1);
      @(posedge clk);
      exp_q.push_back(32'h00000099);
      #1;
      check("first_write_after_release", mem_rdata);
      @(negedge clk);
      drive_mem(32'd20, 32'd0, 1'b0, 1'b0);

      // Every queued expectation must have been consumed
      tests++;
      assert (exp_q.size() == 0) else begin
         failures++;
         $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/exec_mem_unit.md
Name: exec_mem_unit

Overview:
- Execute-and-memory datapath block for the 5-stage MIPS pipeline.
- Combines three functions:
  - ALU-control decoder: ALUop plus funct gives the ALU operation.
  - 32-bit combinational ALU with zero flag and shamt-based shifts.
  - Word-organised data memory: synchronous write, combinational read.
- ALU inputs arrive from ID/EX. Memory address, write data and enables arrive from EX/MEM, so the memory address is a separate port from the ALU result.

Parameters:
- ADDR_W, 8, log2 of data-memory depth in 32-bit words (default 256 words).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_op  in  3  ALUop from the control unit.
- funct  in  6  instruction[5:0] (R-type function field).
- src_a  in  32  ALU operand A (rs data).
- src_b  in  32  ALU operand B (rt data or sign-extended immediate).
- shamt  in  5  shift amount, instruction[10:6].
- alu_ctrl  out  3  decoded ALU operation (exported for debug and verification).
- alu_result  out  32  ALU result.
- zero  out  1  high when alu_result == 0.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data.
- mem_read  in  1  read enable.
- mem_write  in  1  write enable.
- mem_rdata  out  32  load data.

Behaviour:
- ALUop encoding (the ALU-control decoder sets alu_ctrl from it):
  - 000 (lw, sw, addi) gives ADD.
  - 001 (beq, bne) gives SUB.
  - 010 (R-type) decodes funct.
  - 011 (andi) gives AND.
  - 100 (ori) gives OR.
  - 101 (slti) gives SLT.
  - 110 and 111 give ADD.
- funct decode, applied only when ALUop = 010:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR.
  - 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL.
  - Any other funct gives ADD.
- alu_ctrl codes: AND 000, OR 001, ADD 010, SLL 011, SRL 100, NOR 101, SUB 110, SLT 111.
- ALU operations, purely combinational, zero cycles of latency:
  - ADD and SUB wrap modulo 2^32; no overflow detection.
  - AND, OR and NOR are bitwise.
  - SLT is a signed comparison: 32'd1 if src_a < src_b, else 32'd0.
  - SLL gives src_b << shamt.
  - SRL gives src_b >> shamt, logical (zero fill).
  - shamt = 0 gives src_b unchanged.
  - Shifts ignore src_a.
- zero is asserted for every operation whenever alu_result is all zeros.
- The ALU path has no reset dependence; its outputs are valid during reset.
- Memory array: 2^ADDR_W words of 32 bits.
  - Word index is mem_addr[ADDR_W+1:2].
  - mem_addr[1:0] are ignored (no misalignment trap).
  - Upper address bits are ignored, so addresses wrap modulo depth.
- Memory write: on the rising edge of clk, when mem_write = 1 and rst_n = 1, the word at the index is updated with mem_wdata.
- Memory read: combinational.
  - mem_rdata = array[index] while mem_read = 1.
  - mem_rdata = 32'h0 while mem_read = 0.
- Read and write to the same address in the same cycle:
  - Before the edge, mem_rdata shows the old data.
  - After the edge it shows the new data; there is no bypass.
- mem_read = 1 and mem_write = 1 together is legal and behaves as above.
- Reset:
  - rst_n low asynchronously clears every memory word to 0. mem_rdata is therefore 0 throughout reset, regardless of mem_read.
  - Writes are suppressed while rst_n is low.
  - A reset asserted mid-sequence discards all earlier stores.
  - The first write after release takes effect on the first rising edge with rst_n high.
- X handling: unknown alu_op or funct values must never produce X on alu_ctrl; they fall to the default, ADD.

Decomposition:
- Shared package exec_mem_pkg holds:
  - localparams for the ALUop codes, the funct codes and the alu_ctrl codes.
  - The 32-bit data width.
- The ALU-control decoder and the ALU stay as combinational logic in the top module.
- One sub-module is natural: data_mem_array, parameterised by ADDR_W, owning the storage, the reset clear, the write port and the read mux.

Test Plan:
- ALU arithmetic and logic, R-type:
  - alu_op = 010, funct = 0x20, A = 7, B = 5 gives alu_result = 12, zero = 0.
  - funct = 0x22 with A = B = 5 gives 0, zero = 1.
  - funct = 0x2A with A = 32'hFFFFFFFF, B = 1 gives 1; with A = 1, B = 32'hFFFFFFFF it gives 0.
- Logic and shifts, alu_op = 010:
  - funct = 0x24, A = 0xF0F0, B = 0xFF00 gives 0xF000.
  - funct = 0x25 with the same operands gives 0xFFF0.
  - funct = 0x27, A = 0, B = 0 gives 0xFFFFFFFF.
  - funct = 0x00, B = 1, shamt = 4 gives 0x10.
  - funct = 0x02, B = 0x80000000, shamt = 31 gives 1.
- Non-R ALUop decode:
  - 000 gives alu_ctrl = 010; 001 gives 110; 011 gives 000; 100 gives 001; 101 gives 111; 110 and 111 give 010.
  - alu_op = 010 with funct = 0x3F gives 010.
- Memory store and load:
  - Write 32'hDEADBEEF at address 8.
  - Read address 8 (also address 9, alignment ignored) gives DEADBEEF.
  - With mem_read = 0, mem_rdata = 0.
  - Address 8 + 4*256 reads the same word (wrap).
- Same-cycle read and write:
  - Address 12 holds 0x11; write 0x22 with mem_read = 1.
  - mem_rdata = 0x11 before the edge and 0x22 after it.
- Asynchronous reset:
  - After storing 0x55 at address 4, pulse rst_n low between clock edges.
  - mem_rdata at address 4 becomes 0 immediately.
  - A write attempted while rst_n is low is ignored; reading back gives 0.
